// File: rtl/anc_seq_pkg.sv
// Shared types and constants for the ANC sample sequencer.
package anc_seq_pkg;

  // Signed 16-bit sample / step-size word.
  typedef logic signed [15:0] sample_t;

  // Core-side sequencing states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } seq_state_t;

  localparam sample_t MU_ZERO = 16'sd0;

endpackage

// File: rtl/anc_mu_ramp.sv
// LMS step-size generator: soft-start ramp towards a clamped target, freeze to 0.
module anc_mu_ramp
  import anc_seq_pkg::*;
#(
  parameter int MU_STEP = 16
) (
  input  logic    i_clk,
  input  logic    i_rst_n,
  input  logic    i_update,
  input  logic    i_adapt_en,
  input  sample_t i_mu_target,
  output sample_t o_mu_next
);

  sample_t     r_mu;
  sample_t     w_mu_next;
  logic [16:0] w_tgt;
  logic [16:0] w_sum;

  // Next step size: 0 when frozen, else min(mu + step, max(target, 0)).
  // r_mu never goes negative, so a 17-bit unsigned sum cannot wrap.
  always_comb begin
    w_tgt = i_mu_target[15] ? 17'd0 : {1'b0, i_mu_target};
    w_sum = {1'b0, r_mu} + 17'(MU_STEP);
    if (!i_adapt_en) begin
      w_mu_next = MU_ZERO;
    end else if (w_sum > w_tgt) begin
      w_mu_next = sample_t'(w_tgt[15:0]);
    end else begin
      w_mu_next = sample_t'(w_sum[15:0]);
    end
  end

  // Step-size register, advanced only when a sample is issued.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_mu <= MU_ZERO;
    end else if (i_update) begin
      r_mu <= w_mu_next;
    end
  end

  assign o_mu_next = w_mu_next;

endmodule

// File: rtl/anc_sample_sequencer.sv
// Core-side sequencer: buffers one sample set, issues it to the ANC core,
// waits (with watchdog) for the filter output and returns it to the DAC side.
module anc_sample_sequencer
  import anc_seq_pkg::*;
#(
  parameter int TIMEOUT = 2048,
  parameter int TMR_W   = 12,
  parameter int MU_STEP = 16,
  parameter int CNT_W   = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_smp_valid,
  input  sample_t          i_smp_e,
  input  sample_t          i_smp_x,
  input  sample_t          i_smp_a,
  input  logic             i_adapt_en,
  input  sample_t          i_mu_target,
  input  logic             i_clr_err,
  input  logic             i_core_ready,
  output logic             o_core_in_valid,
  output sample_t          o_core_e,
  output sample_t          o_core_x,
  output sample_t          o_core_a,
  output sample_t          o_core_u,
  input  sample_t          i_core_out_sample,
  input  logic             i_core_out_valid,
  output sample_t          o_dac_sample,
  output logic             o_dac_valid,
  output logic             o_busy,
  output logic [CNT_W-1:0] o_overrun_cnt,
  output logic             o_err_overrun,
  output logic             o_err_timeout,
  output logic             o_err_stray
);

  seq_state_t       r_state;
  seq_state_t       w_state_next;
  logic             r_pend;
  sample_t          r_pend_e, r_pend_x, r_pend_a;
  logic [TMR_W-1:0] r_timer;
  logic             r_core_in_valid;
  sample_t          r_core_e, r_core_x, r_core_a, r_core_u;
  sample_t          r_dac_sample;
  logic             r_dac_valid;
  logic [CNT_W-1:0] r_ovr_cnt;
  logic             r_err_overrun, r_err_timeout, r_err_stray;

  logic             w_drain;
  logic             w_done_ok;
  logic             w_done_tmo;
  logic             w_stray;
  logic             w_overrun;
  sample_t          w_mu_next;

  anc_mu_ramp #(
    .MU_STEP (MU_STEP)
  ) u_mu_ramp (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_update    (w_drain),
    .i_adapt_en  (i_adapt_en),
    .i_mu_target (i_mu_target),
    .o_mu_next   (w_mu_next)
  );

  // A new sample is dropped only if the buffer is full and not emptying now.
  assign w_overrun = i_smp_valid && r_pend && !w_drain;

  // FSM state register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state and event decode; core_ready matters only while idle.
  always_comb begin
    w_state_next = r_state;
    w_drain      = 1'b0;
    w_done_ok    = 1'b0;
    w_done_tmo   = 1'b0;
    w_stray      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_stray = i_core_out_valid;
        if (r_pend && i_core_ready) begin
          w_drain      = 1'b1;
          w_state_next = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        w_stray      = i_core_out_valid;
        w_state_next = ST_WAIT;
      end
      ST_WAIT: begin
        // A response on the last watchdog cycle still counts as completion.
        if (i_core_out_valid) begin
          w_done_ok    = 1'b1;
          w_state_next = ST_IDLE;
        end else if (r_timer == TMR_W'(TIMEOUT - 1)) begin
          w_done_tmo   = 1'b1;
          w_state_next = ST_IDLE;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Depth-1 pending buffer; a drain and a new load may share an edge.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pend   <= 1'b0;
      r_pend_e <= MU_ZERO;
      r_pend_x <= MU_ZERO;
      r_pend_a <= MU_ZERO;
    end else if (i_smp_valid && (!r_pend || w_drain)) begin
      r_pend   <= 1'b1;
      r_pend_e <= i_smp_e;
      r_pend_x <= i_smp_x;
      r_pend_a <= i_smp_a;
    end else if (w_drain) begin
      r_pend <= 1'b0;
    end
  end

  // Issue path: operands and step size latched as the buffer drains.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_core_in_valid <= 1'b0;
      r_core_e        <= MU_ZERO;
      r_core_x        <= MU_ZERO;
      r_core_a        <= MU_ZERO;
      r_core_u        <= MU_ZERO;
    end else begin
      r_core_in_valid <= w_drain;
      if (w_drain) begin
        r_core_e <= r_pend_e;
        r_core_x <= r_pend_x;
        r_core_a <= r_pend_a;
        r_core_u <= w_mu_next;
      end
    end
  end

  // Completion watchdog: cleared in ISSUE, counts cycles spent in WAIT.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_timer <= '0;
    end else if (r_state == ST_ISSUE) begin
      r_timer <= '0;
    end else if (r_state == ST_WAIT) begin
      r_timer <= r_timer + 1'b1;
    end
  end

  // DAC return: new data on completion, held data on timeout.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_dac_sample <= MU_ZERO;
      r_dac_valid  <= 1'b0;
    end else begin
      r_dac_valid <= w_done_ok || w_done_tmo;
      if (w_done_ok) begin
        r_dac_sample <= i_core_out_sample;
      end
    end
  end

  // Sticky status; a set event in the same cycle as clr_err takes priority.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ovr_cnt     <= '0;
      r_err_overrun <= 1'b0;
      r_err_timeout <= 1'b0;
      r_err_stray   <= 1'b0;
    end else begin
      if (i_clr_err) begin
        r_ovr_cnt     <= '0;
        r_err_overrun <= 1'b0;
        r_err_timeout <= 1'b0;
        r_err_stray   <= 1'b0;
      end
      if (w_overrun) begin
        r_err_overrun <= 1'b1;
        if (i_clr_err) begin
          r_ovr_cnt <= CNT_W'(1);
        end else if (r_ovr_cnt != '1) begin
          r_ovr_cnt <= r_ovr_cnt + 1'b1;
        end
      end
      if (w_done_tmo) begin
        r_err_timeout <= 1'b1;
      end
      if (w_stray) begin
        r_err_stray <= 1'b1;
      end
    end
  end

  assign o_core_in_valid = r_core_in_valid;
  assign o_core_e        = r_core_e;
  assign o_core_x        = r_core_x;
  assign o_core_a        = r_core_a;
  assign o_core_u        = r_core_u;
  assign o_dac_sample    = r_dac_sample;
  assign o_dac_valid     = r_dac_valid;
  assign o_busy          = (r_state != ST_IDLE);
  assign o_overrun_cnt   = r_ovr_cnt;
  assign o_err_overrun   = r_err_overrun;
  assign o_err_timeout   = r_err_timeout;
  assign o_err_stray     = r_err_stray;

endmodule

// File: tb/tb_anc_sample_sequencer.sv
// Randomized self-checking bench for anc_sample_sequencer against a
// transaction-level reference model.
module tb_anc_sample_sequencer;
  import anc_seq_pkg::*;

  localparam int TIMEOUT = 64;
  localparam int TMR_W   = 12;
  localparam int MU_STEP = 16;
  localparam int CNT_W   = 8;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             smp_valid = 1'b0;
  sample_t          smp_e = '0, smp_x = '0, smp_a = '0;
  logic             adapt_en = 1'b0;
  sample_t          mu_target = '0;
  logic             clr_err = 1'b0;
  logic             core_ready = 1'b0;
  logic             core_in_valid;
  sample_t          core_e, core_x, core_a, core_u;
  sample_t          core_out_sample = '0;
  logic             core_out_valid = 1'b0;
  sample_t          dac_sample;
  logic             dac_valid, busy;
  logic [CNT_W-1:0] overrun_cnt;
  logic             err_overrun, err_timeout, err_stray;

  int n_total = 0;
  int n_pass  = 0;
  int n_txn   = 0;

  // Reference model state
  int mdl_mu   = 0;
  int mdl_ovr  = 0;
  int mdl_dac  = 0;
  bit mdl_eovr = 1'b0;
  bit mdl_etmo = 1'b0;
  bit mdl_estr = 1'b0;

  int ramp_exp [6] = '{16, 32, 40, 40, 0, 0};

  always #5 clk = ~clk;

  anc_sample_sequencer #(
    .TIMEOUT (TIMEOUT),
    .TMR_W   (TMR_W),
    .MU_STEP (MU_STEP),
    .CNT_W   (CNT_W)
  ) dut (
    .i_clk             (clk),
    .i_rst_n           (rst_n),
    .i_smp_valid       (smp_valid),
    .i_smp_e           (smp_e),
    .i_smp_x           (smp_x),
    .i_smp_a           (smp_a),
    .i_adapt_en        (adapt_en),
    .i_mu_target       (mu_target),
    .i_clr_err         (clr_err),
    .i_core_ready      (core_ready),
    .o_core_in_valid   (core_in_valid),
    .o_core_e          (core_e),
    .o_core_x          (core_x),
    .o_core_a          (core_a),
    .o_core_u          (core_u),
    .i_core_out_sample (core_out_sample),
    .i_core_out_valid  (core_out_valid),
    .o_dac_sample      (dac_sample),
    .o_dac_valid       (dac_valid),
    .o_busy            (busy),
    .o_overrun_cnt     (overrun_cnt),
    .o_err_overrun     (err_overrun),
    .o_err_timeout     (err_timeout),
    .o_err_stray       (err_stray)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    n_total++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: observed=%0d expected=%0d (t=%0t)", tag, obs, exp, $time);
  endtask

  // Step-size rule: 0 when frozen, else min(mu + step, max(target, 0)).
  function automatic int next_mu(int cur, bit en, int target);
    int tgt;
    int sum;
    tgt = (target < 0) ? 0 : target;
    sum = cur + MU_STEP;
    if (!en) return 0;
    return (sum < tgt) ? sum : tgt;
  endfunction

  task automatic check_flags;
    chk("err_overrun", err_overrun, int'(mdl_eovr));
    chk("err_timeout", err_timeout, int'(mdl_etmo));
    chk("err_stray", err_stray, int'(mdl_estr));
    chk("overrun_cnt", overrun_cnt, mdl_ovr);
  endtask

  task automatic clear_errors;
    clr_err = 1'b1;
    tick;
    clr_err = 1'b0;
    mdl_eovr = 0; mdl_etmo = 0; mdl_estr = 0; mdl_ovr = 0;
    check_flags;
  endtask

  task automatic check_all_zero(input string tag);
    int acc;
    acc = int'(core_in_valid) + int'(core_e != 0) + int'(core_x != 0) + int'(core_a != 0)
        + int'(core_u != 0) + int'(dac_sample != 0) + int'(dac_valid) + int'(busy)
        + int'(overrun_cnt != 0) + int'(err_overrun) + int'(err_timeout) + int'(err_stray);
    chk(tag, acc, 0);
  endtask

  // Deliver a sample (or rely on one already pending), optionally hold
  // core_ready low for d cycles, and check the resulting issue.
  task automatic issue_phase(input bit drive, input sample_t e, input sample_t x,
                             input sample_t a, input int d);
    int early;
    early = 0;
    if (drive) begin
      smp_valid  = 1'b1;
      smp_e      = e;
      smp_x      = x;
      smp_a      = a;
      core_ready = (d == 0);
      tick;
      smp_valid = 1'b0;
    end
    for (int i = 0; i < d; i++) begin
      core_ready = 1'b0;
      tick;
      if (core_in_valid) early++;
    end
    core_ready = 1'b1;
    tick;
    if (d > 0) chk("no_issue_while_not_ready", early, 0);
    mdl_mu = next_mu(mdl_mu, adapt_en, int'(mu_target));
    chk("core_in_valid", core_in_valid, 1);
    chk("core_e", core_e, e);
    chk("core_x", core_x, x);
    chk("core_a", core_a, a);
    chk("core_u", core_u, mdl_mu);
    chk("busy_issue", busy, 1);
    chk("dac_valid_idle", dac_valid, 0);
  endtask

  // From the issue cycle: inject n_extra new samples during WAIT, then either
  // answer after lat cycles or let the watchdog expire; check the DAC side.
  task automatic resp_phase(input bit respond, input int lat, input sample_t r,
                            input int n_extra, output sample_t fe, output sample_t fx,
                            output sample_t fa);
    int lim;
    lim = respond ? lat : TIMEOUT;
    fe = '0; fx = '0; fa = '0;
    for (int w = 1; w <= lim; w++) begin
      tick;
      if (w == 1) chk("issue_one_cycle", core_in_valid, 0);
      smp_valid = (w <= n_extra);
      smp_e = sample_t'($urandom);
      smp_x = sample_t'($urandom);
      smp_a = sample_t'($urandom);
      if (w == 1) begin
        fe = smp_e; fx = smp_x; fa = smp_a;
      end
      core_ready      = 1'($urandom);
      core_out_valid  = respond && (w == lim);
      core_out_sample = respond ? r : sample_t'($urandom);
      if (!respond && w == lim) chk("timeout_not_early", err_timeout, int'(mdl_etmo));
    end
    tick;
    smp_valid      = 1'b0;
    core_out_valid = 1'b0;
    core_ready     = 1'b1;
    if (!respond) mdl_etmo = 1'b1;
    else mdl_dac = int'(r);
    if (n_extra > 1) begin
      mdl_eovr = 1'b1;
      mdl_ovr  = (mdl_ovr + n_extra - 1 > CNT_MAX) ? CNT_MAX : mdl_ovr + n_extra - 1;
    end
    chk("dac_valid", dac_valid, 1);
    chk("dac_sample", dac_sample, mdl_dac);
    chk("busy_done", busy, 0);
    check_flags;
    n_txn++;
    $display("txn %0d: e=%0d x=%0d a=%0d u=%0d %s lat=%0d extra=%0d dac=%0d ovr=%0d",
             n_txn, core_e, core_x, core_a, core_u, respond ? "resp" : "timeout",
             lim, n_extra, dac_sample, overrun_cnt);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "bench time limit");
  end

  initial begin
    sample_t fe, fx, fa;
    int      lat, n_extra, d;
    bit      resp;

    // Reset state
    rst_n = 1'b0;
    repeat (3) tick;
    check_all_zero("reset_outputs_zero");
    rst_n = 1'b1;
    tick;

    // Soft-start ramp, freeze, negative target
    adapt_en  = 1'b1;
    mu_target = sample_t'(40);
    for (int i = 0; i < 6; i++) begin
      if (i == 4) adapt_en = 1'b0;
      if (i == 5) begin
        adapt_en  = 1'b1;
        mu_target = sample_t'(-3);
      end
      issue_phase(1'b1, sample_t'($urandom), sample_t'($urandom), sample_t'($urandom), 0);
      chk("ramp_core_u", core_u, ramp_exp[i]);
      resp_phase(1'b1, 5, sample_t'($urandom), 0, fe, fx, fa);
    end

    // Basic flow
    adapt_en  = 1'b1;
    mu_target = sample_t'(1000);
    issue_phase(1'b1, sample_t'(100), sample_t'(-5), sample_t'(7), 0);
    resp_phase(1'b1, 40, sample_t'(16'h1234), 0, fe, fx, fa);

    // Overrun: three strobes during WAIT, first is kept and issued next
    issue_phase(1'b1, sample_t'($urandom), sample_t'($urandom), sample_t'($urandom), 0);
    resp_phase(1'b1, 10, sample_t'($urandom), 3, fe, fx, fa);
    issue_phase(1'b0, fe, fx, fa, 0);
    resp_phase(1'b1, 7, sample_t'($urandom), 0, fe, fx, fa);
    clear_errors;

    // Timeout with a pending sample, then a reply on the last watchdog cycle
    issue_phase(1'b1, sample_t'($urandom), sample_t'($urandom), sample_t'($urandom), 0);
    resp_phase(1'b0, 0, '0, 1, fe, fx, fa);
    clr_err  = 1'b1;
    mdl_eovr = 0; mdl_etmo = 0; mdl_estr = 0; mdl_ovr = 0;
    issue_phase(1'b0, fe, fx, fa, 0);
    clr_err = 1'b0;
    resp_phase(1'b1, TIMEOUT, sample_t'($urandom), 0, fe, fx, fa);

    // Stray output in IDLE, coincident with clr_err (set wins)
    clr_err         = 1'b1;
    core_out_valid  = 1'b1;
    core_out_sample = sample_t'($urandom);
    tick;
    clr_err        = 1'b0;
    core_out_valid = 1'b0;
    mdl_eovr = 0; mdl_etmo = 0; mdl_ovr = 0; mdl_estr = 1;
    chk("stray_no_dac_valid", dac_valid, 0);
    chk("stray_dac_hold", dac_sample, mdl_dac);
    check_flags;

    // Back-pressure: core_ready low for 100 cycles
    issue_phase(1'b1, sample_t'($urandom), sample_t'($urandom), sample_t'($urandom), 100);
    resp_phase(1'b1, 12, sample_t'($urandom), 0, fe, fx, fa);

    // Overrun counter saturation across chained timeouts
    clear_errors;
    issue_phase(1'b1, sample_t'($urandom), sample_t'($urandom), sample_t'($urandom), 0);
    for (int k = 0; k < 5; k++) begin
      resp_phase(1'b0, 0, '0, TIMEOUT, fe, fx, fa);
      issue_phase(1'b0, fe, fx, fa, 0);
    end
    resp_phase(1'b1, 3, sample_t'($urandom), 0, fe, fx, fa);
    clear_errors;

    // Randomized transactions
    for (int t = 0; t < 25; t++) begin
      adapt_en  = ($urandom_range(0, 3) != 0);
      mu_target = sample_t'(int'($urandom_range(0, 140)) - 20);
      d         = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 6)) : 0;
      resp      = ($urandom_range(0, 7) != 0);
      lat       = $urandom_range(1, TIMEOUT);
      n_extra   = $urandom_range(0, 2);
      if (n_extra > lat) n_extra = lat;
      issue_phase(1'b1, sample_t'($urandom), sample_t'($urandom), sample_t'($urandom), d);
      resp_phase(resp, lat, sample_t'($urandom), n_extra, fe, fx, fa);
      if (n_extra > 0) begin
        issue_phase(1'b0, fe, fx, fa, 0);
        resp_phase(1'b1, $urandom_range(1, TIMEOUT), sample_t'($urandom), 0, fe, fx, fa);
      end
    end

    // Reset in the middle of WAIT
    issue_phase(1'b1, sample_t'(16'h7abc), sample_t'(-1), sample_t'(3), 0);
    tick;
    tick;
    rst_n = 1'b0;
    #1;
    check_all_zero("reset_mid_wait_zero");
    tick;
    rst_n = 1'b1;
    mdl_mu = 0; mdl_ovr = 0; mdl_dac = 0;
    mdl_eovr = 0; mdl_etmo = 0; mdl_estr = 0;
    tick;
    core_out_valid  = 1'b1;
    core_out_sample = sample_t'(16'h0555);
    tick;
    core_out_valid = 1'b0;
    mdl_estr = 1;
    chk("late_out_no_dac_valid", dac_valid, 0);
    chk("late_out_dac_zero", dac_sample, 0);
    check_flags;
    issue_phase(1'b1, sample_t'($urandom), sample_t'($urandom), sample_t'($urandom), 0);
    resp_phase(1'b1, 9, sample_t'($urandom), 0, fe, fx, fa);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
